dmem_responder: RTL and testbench

Memory-side responder for the pipeline's MEM-stage data port. It accepts one load or store request at a time over a valid/ready handshake and holds a word-addressed 64-bit storage array. It inserts a configurable number of wait states, then returns read data or a write acknowledgement over a valid/ready response channel. This replaces the zero-latency data memory model so the CPU's MEM stage can be exercised against a realistic multi-cycle memory.

---
 rtl/dmem_if.sv | 20 ++
 rtl/dmem_responder.sv | 80 ++++++++
 tb/tb_dmem_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: valid/ready request and response bus between the MEM stage and its data memory
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory with configurable wait states and registered response
module dmem_responder #(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, err_q, resp_err_q;
  logic [AW-1:0]   idx_q;
  logic [63:0]     wdata_q, rdata_q;
  logic [63:0]     mem [DEPTH];
  logic            hs, in_err, commit, cur_write, cur_err;
  logic [AW-1:0]   cur_idx;
  logic [63:0]     cur_wdata;
  assign hs     = bus.req_valid && state_q == IDLE;
  assign in_err = (bus.req_addr[2:0] != 3'd0) || (bus.req_addr[63:AW+3] != '0);
  // With zero wait states the commit edge is the acceptance edge, so the live inputs are used there
  assign cur_write = state_q == IDLE ? bus.req_write          : write_q;
  assign cur_err   = state_q == IDLE ? in_err                 : err_q;
  assign cur_idx   = state_q == IDLE ? bus.req_addr[3 +: AW]  : idx_q;
  assign cur_wdata = state_q == IDLE ? bus.req_wdata          : wdata_q;
  assign commit    = state_d == RESP && state_q != RESP;
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = resp_err_q;
  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (hs) begin
        state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
        cnt_d   = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
      end
      WAIT: begin
        state_d = cnt_q == 4'd0 ? RESP : WAIT;
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
      RESP: state_d = bus.resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // State, request capture and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) begin
        write_q <= bus.req_write;
        err_q   <= in_err;
        idx_q   <= bus.req_addr[3 +: AW];
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        rdata_q    <= (cur_err || cur_write) ? 64'd0 : mem[cur_idx];
        resp_err_q <= cur_err;
      end
    end
  end
  // Storage is never reset; a store only lands on the edge that enters RESP
  always_ff @(posedge clk) begin
    if (rst_n && commit && cur_write && !cur_err) mem[cur_idx] <= cur_wdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table-driven bench for dmem_responder
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dmem_if bus();
  dmem_if bus0();
  dmem_responder #(.DEPTH(128), .WAIT_CYCLES(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  dmem_responder #(.DEPTH(128), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
  } vec_t;
  vec_t v[14];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                         input int hold, output logic [63:0] rdata, output logic err, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("req_ready_before_req", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~wr;
    bus.req_addr  = '1;
    bus.req_wdata = '1;
    lat = 1;
    @(negedge clk);
    while (!bus.resp_valid && lat < 50) begin
      check("busy_req_ready", bus.req_ready, 0);
      @(negedge clk);
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_resp_valid", bus.resp_valid, 1);
      check("hold_resp_rdata", bus.resp_rdata, rdata);
      check("hold_resp_err", bus.resp_err, err);
      check("hold_req_ready", bus.req_ready, 0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    check("done_resp_valid", bus.resp_valid, 0);
    check("done_req_ready", bus.req_ready, 1);
  endtask
  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    logic [63:0] a;
    a = 64'hCAFE_F00D_1234_5678;
    v[0]  = '{1'b1, 64'h40,                  64'h0123_4567_89AB_CDEF, 64'h0,                   1'b0};
    v[1]  = '{1'b0, 64'h40,                  64'h0,                   64'h0123_4567_89AB_CDEF, 1'b0};
    v[2]  = '{1'b1, 64'h44,                  64'hDEAD_BEEF,           64'h0,                   1'b1};
    v[3]  = '{1'b0, 64'h40,                  64'h0,                   64'h0123_4567_89AB_CDEF, 1'b0};
    v[4]  = '{1'b0, 64'h400,                 64'h0,                   64'h0,                   1'b1};
    v[5]  = '{1'b0, 64'h8000_0000_0000_0000, 64'h0,                   64'h0,                   1'b1};
    v[6]  = '{1'b1, 64'h3F8,                 64'hAAAA,                64'h0,                   1'b0};
    v[7]  = '{1'b0, 64'h3F8,                 64'h0,                   64'hAAAA,                1'b0};
    v[8]  = '{1'b1, 64'h8,                   64'h77,                  64'h0,                   1'b0};
    v[9]  = '{1'b1, 64'h408,                 64'h99,                  64'h0,                   1'b1};
    v[10] = '{1'b0, 64'h8,                   64'h0,                   64'h77,                  1'b0};
    v[11] = '{1'b1, 64'h10,                  64'h1234,                64'h0,                   1'b0};
    v[12] = '{1'b0, 64'h10,                  64'h0,                   64'h1234,                1'b0};
    v[13] = '{1'b0, 64'h0,                   64'h0,                   64'h0,                   1'b1};
    v[13].addr = 64'h1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    bus0.req_valid  = 1'b0;
    bus0.req_write  = 1'b0;
    bus0.req_addr   = '0;
    bus0.req_wdata  = '0;
    bus0.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_err", bus.resp_err, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      run_req(v[i].wr, v[i].addr, v[i].wdata, 0, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, v[i].rdata);
      check($sformatf("vec%0d_err", i), er, v[i].err);
      check($sformatf("vec%0d_latency", i), lat, 3);
    end
    run_req(1'b0, 64'h40, 64'h0, 10, rd, er, lat);
    check("bp_rdata", rd, 64'h0123_4567_89AB_CDEF);
    check("bp_err", er, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 64'h10;
    bus.req_wdata = 64'hFFFF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_wait_req_ready", bus.req_ready, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_req_ready", bus.req_ready, 1);
    check("async_rst_resp_valid", bus.resp_valid, 0);
    check("async_rst_resp_rdata", bus.resp_rdata, 0);
    check("async_rst_resp_err", bus.resp_err, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(1'b0, 64'h10, 64'h0, 0, rd, er, lat);
    check("after_rst_rdata", rd, 64'h1234);
    check("after_rst_err", er, 0);
    @(negedge clk);
    check("zw_idle_ready", bus0.req_ready, 1);
    bus0.req_valid = 1'b1;
    bus0.req_write = 1'b1;
    bus0.req_addr  = 64'h20;
    bus0.req_wdata = a;
    @(negedge clk);
    check("zw_st_valid", bus0.resp_valid, 1);
    check("zw_st_busy", bus0.req_ready, 0);
    check("zw_st_err", bus0.resp_err, 0);
    check("zw_st_rdata", bus0.resp_rdata, 0);
    bus0.req_write = 1'b0;
    @(negedge clk);
    check("zw_ready_again", bus0.req_ready, 1);
    check("zw_gap_valid", bus0.resp_valid, 0);
    @(negedge clk);
    check("zw_ld1_valid", bus0.resp_valid, 1);
    check("zw_ld1_rdata", bus0.resp_rdata, a);
    @(negedge clk);
    check("zw_ld1_ready_again", bus0.req_ready, 1);
    @(negedge clk);
    check("zw_ld2_valid", bus0.resp_valid, 1);
    check("zw_ld2_rdata", bus0.resp_rdata, a);
    bus0.req_valid = 1'b0;
    @(negedge clk);
    check("zw_end_valid", bus0.resp_valid, 0);
    check("zw_end_ready", bus0.req_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
